// File: rtl/riscv_pkg.sv
// riscv_pkg: shared pipeline constants and the IF/ID register payload type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  typedef struct packed {
    logic [31:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic valid;
  } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register (d/q payload) with bubble over hold over capture priority
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   stall,
  input  if_id_t d,
  output if_id_t q
);
  always_ff @(posedge clk)
    if (rst) q <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};
    else if (flush) begin
      q.instr <= NOP_INSTR;
      q.valid <= 1'b0;
    end
    else if (!stall) q <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, next-PC mux and IF/ID register; redirect > stall > pc+4, imem read same cycle
module fetch_stage #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            misalign_d,
  output logic [31:0]     fetch_count
);
  import riscv_pkg::*;
  logic [XLEN-1:0] pc_f;
  if_id_t d, q;
  always_ff @(posedge clk)
    if (rst) pc_f <= RESET_PC;
    else if (pc_src_e) pc_f <= {pc_target_e[XLEN-1:2], 2'b00};
    else if (!stall_f) pc_f <= pc_f + XLEN'(4);
  always_ff @(posedge clk)
    if (rst) misalign_d <= 1'b0;
    else if (pc_src_e && |pc_target_e[1:0]) misalign_d <= 1'b1;
  always_ff @(posedge clk)
    if (rst) fetch_count <= '0;
    else if (!flush_d && !pc_src_e && !stall_d) fetch_count <= fetch_count + 32'd1;
  assign d = '{instr: imem_rdata, pc: pc_f, pc_plus4: pc_f + XLEN'(4), valid: 1'b1};
  if_id_reg u_if_id (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_d | pc_src_e),
    .stall (stall_d),
    .d     (d),
    .q     (q)
  );
  assign imem_addr  = pc_f;
  assign instr_d    = q.instr;
  assign pc_d       = q.pc;
  assign pc_plus4_d = q.pc_plus4;
  assign valid_d    = q.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven scoreboard bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 0, rst = 1, stall_f = 0, stall_d = 0, flush_d = 0, pc_src_e = 0;
  logic [31:0] pc_target_e = '0, imem_addr, imem_rdata, instr_d, pc_d, pc_plus4_d, fetch_count;
  logic valid_d, misalign_d;
  int applied = 0, miscompares = 0, vec_no = 0;
  typedef struct {
    logic rst, sf, sd, fl, ps;
    logic [31:0] tgt, pc, instr, pcd, pp4;
    logic v, mis;
    logic [31:0] cnt;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .misalign_d(misalign_d), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'h0010_0093 + (a >> 2) * 32'h0010_0080;
  endfunction
  assign imem_rdata = w(imem_addr);
  function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] tgt, pc, instr, pcd, pp4,
                              input logic v, mis, input logic [31:0] cnt);
    vec_t r;
    {r.rst, r.sf, r.sd, r.fl, r.ps} = ctl;
    r.tgt = tgt; r.pc = pc; r.instr = instr; r.pcd = pcd; r.pp4 = pp4;
    r.v = v; r.mis = mis; r.cnt = cnt;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %h expected %h", name, vec_no, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    vec_t e;
    @(negedge clk);
    {rst, stall_f, stall_d, flush_d, pc_src_e} = {v.rst, v.sf, v.sd, v.fl, v.ps};
    pc_target_e = v.tgt;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc_f", imem_addr, e.pc);
    chk("instr_d", instr_d, e.instr);
    chk("pc_d", pc_d, e.pcd);
    chk("pc_plus4_d", pc_plus4_d, e.pp4);
    chk("valid_d", {31'd0, valid_d}, {31'd0, e.v});
    chk("misalign_d", {31'd0, misalign_d}, {31'd0, e.mis});
    chk("fetch_count", fetch_count, e.cnt);
    vec_no++;
  endtask
  localparam logic [4:0] R = 5'b10000, SF = 5'b01000, SD = 5'b00100, FL = 5'b00010, PS = 5'b00001, GO = 5'b0;
  initial begin
    tbl.push_back(mk(R,       0, 0, NOP, 0, 0, 0, 0, 0));
    tbl.push_back(mk(R,       0, 0, NOP, 0, 0, 0, 0, 0));
    tbl.push_back(mk(GO,      0, 4, w(0), 0, 4, 1, 0, 1));
    tbl.push_back(mk(GO,      0, 8, w(4), 4, 8, 1, 0, 2));
    tbl.push_back(mk(SF|SD,   0, 8, w(4), 4, 8, 1, 0, 2));
    tbl.push_back(mk(SF|SD,   0, 8, w(4), 4, 8, 1, 0, 2));
    tbl.push_back(mk(SF|SD,   0, 8, w(4), 4, 8, 1, 0, 2));
    tbl.push_back(mk(GO,      0, 'hC, w(8), 8, 'hC, 1, 0, 3));
    tbl.push_back(mk(GO,      0, 'h10, w('hC), 'hC, 'h10, 1, 0, 4));
    tbl.push_back(mk(PS,      'h40, 'h40, NOP, 'hC, 'h10, 0, 0, 4));
    tbl.push_back(mk(GO,      0, 'h44, w('h40), 'h40, 'h44, 1, 0, 5));
    tbl.push_back(mk(PS|SF|SD,'h22, 'h20, NOP, 'h40, 'h44, 0, 1, 5));
    tbl.push_back(mk(GO,      0, 'h24, w('h20), 'h20, 'h24, 1, 1, 6));
    tbl.push_back(mk(FL|SD,   0, 'h28, NOP, 'h20, 'h24, 0, 1, 6));
    tbl.push_back(mk(PS,      'hFFFF_FFFC, 'hFFFF_FFFC, NOP, 'h20, 'h24, 0, 1, 6));
    tbl.push_back(mk(GO,      0, 0, w('hFFFF_FFFC), 'hFFFF_FFFC, 0, 1, 1, 7));
    tbl.push_back(mk(GO,      0, 4, w(0), 0, 4, 1, 1, 8));
    tbl.push_back(mk(SD,      0, 8, w(0), 0, 4, 1, 1, 8));
    tbl.push_back(mk(R|PS,    'h80, 0, NOP, 0, 0, 0, 0, 0));
    tbl.push_back(mk(GO,      0, 4, w(0), 0, 4, 1, 0, 1));
    foreach (tbl[i]) run(tbl[i]);
    run(mk(PS, 'h3, 0, NOP, 0, 4, 0, 1, 1));
    run(mk(GO, 0, 4, w(0), 0, 4, 1, 1, 2));
    run(mk(GO, 0, 8, w(4), 4, 8, 1, 1, 3));
    run(mk(SF|SD|FL, 0, 8, NOP, 4, 8, 0, 1, 3));
    run(mk(R, 0, 0, NOP, 0, 0, 0, 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end
endmodule
